ex_operand_stage: RTL and testbench

//  ID/EX pipeline register plus EX-stage operand forwarding for the RV32 pipeline.

---
 rtl/ex_operand_stage.sv | 196 +++++++++++++++++++
 tb/tb_ex_operand_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding for the RV32 pipeline.
// Holds one decoded instruction, resolves RAW hazards from EX/MEM and MEM/WB, and stalls ID on load-use.
module ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  // ID side
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_asel,
  input  logic [1:0]      id_bsel,
  input  logic [3:0]      id_aluctr,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_memwrite,
  // pipeline control
  input  logic            ex_ready,
  input  logic            ex_flush,
  // forwarding sources
  input  logic [RA_W-1:0] mem_rd,
  input  logic            mem_regwrite,
  input  logic [XLEN-1:0] mem_result,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_regwrite,
  input  logic [XLEN-1:0] wb_data,
  // ALU and EX/MEM side
  output logic [XLEN-1:0] alu_da,
  output logic [XLEN-1:0] alu_db,
  output logic [3:0]      alu_aluctr,
  output logic            ex_valid,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic [XLEN-1:0] ex_store_data
);

  localparam logic [XLEN-1:0] CONST_FOUR = XLEN'(4);

  logic            valid_reg,    valid_next;
  logic [XLEN-1:0] pc_reg,       pc_next;
  logic [XLEN-1:0] rs1_data_reg, rs1_data_next;
  logic [XLEN-1:0] rs2_data_reg, rs2_data_next;
  logic [XLEN-1:0] imm_reg,      imm_next;
  logic [RA_W-1:0] rs1_reg,      rs1_next;
  logic [RA_W-1:0] rs2_reg,      rs2_next;
  logic [RA_W-1:0] rd_reg,       rd_next;
  logic            asel_reg,     asel_next;
  logic [1:0]      bsel_reg,     bsel_next;
  logic [3:0]      aluctr_reg,   aluctr_next;
  logic            regwrite_reg, regwrite_next;
  logic            memread_reg,  memread_next;
  logic            memwrite_reg, memwrite_next;

  logic            advance;
  logic            load_use;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // Forwarding network: index 0 is rs1, index 1 is rs2. MEM beats WB; x0 is never forwarded.
  logic [1:0][RA_W-1:0] src_idx;
  logic [1:0][XLEN-1:0] src_data;
  logic [1:0][XLEN-1:0] fwd_data;

  assign src_idx  = {rs2_reg, rs1_reg};
  assign src_data = {rs2_data_reg, rs1_data_reg};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic mem_hit;
      logic wb_hit;
      assign mem_hit = mem_regwrite && (mem_rd != '0) && (mem_rd == src_idx[gi]);
      assign wb_hit  = wb_regwrite && (wb_rd != '0) && (wb_rd == src_idx[gi]);
      assign fwd_data[gi] = mem_hit ? mem_result : (wb_hit ? wb_data : src_data[gi]);
    end
  endgenerate

  assign fwd_rs1 = fwd_data[0];
  assign fwd_rs2 = fwd_data[1];

  assign advance  = ex_ready || !valid_reg;
  assign load_use = valid_reg && memread_reg && (rd_reg != '0) &&
                    ((rd_reg == id_rs1) || (rd_reg == id_rs2)) && id_valid;
  assign id_ready = advance && !load_use;

  always_comb begin
    valid_next    = valid_reg;
    pc_next       = pc_reg;
    rs1_data_next = rs1_data_reg;
    rs2_data_next = rs2_data_reg;
    imm_next      = imm_reg;
    rs1_next      = rs1_reg;
    rs2_next      = rs2_reg;
    rd_next       = rd_reg;
    asel_next     = asel_reg;
    bsel_next     = bsel_reg;
    aluctr_next   = aluctr_reg;
    regwrite_next = regwrite_reg;
    memread_next  = memread_reg;
    memwrite_next = memwrite_reg;

    if (ex_flush || (advance && (load_use || !id_valid))) begin
      // Kill or bubble: only the control side needs clearing.
      valid_next    = 1'b0;
      aluctr_next   = '0;
      regwrite_next = 1'b0;
      memread_next  = 1'b0;
      memwrite_next = 1'b0;
    end else if (!advance) begin
      // Latch forwarded operands so a source retiring from WB mid-stall is not lost.
      rs1_data_next = fwd_rs1;
      rs2_data_next = fwd_rs2;
    end else begin
      valid_next    = 1'b1;
      pc_next       = id_pc;
      rs1_data_next = id_rs1_data;
      rs2_data_next = id_rs2_data;
      imm_next      = id_imm;
      rs1_next      = id_rs1;
      rs2_next      = id_rs2;
      rd_next       = id_rd;
      asel_next     = id_asel;
      bsel_next     = id_bsel;
      aluctr_next   = id_aluctr;
      regwrite_next = id_regwrite;
      memread_next  = id_memread;
      memwrite_next = id_memwrite;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg    <= 1'b0;
      pc_reg       <= '0;
      rs1_data_reg <= '0;
      rs2_data_reg <= '0;
      imm_reg      <= '0;
      rs1_reg      <= '0;
      rs2_reg      <= '0;
      rd_reg       <= '0;
      asel_reg     <= 1'b0;
      bsel_reg     <= '0;
      aluctr_reg   <= '0;
      regwrite_reg <= 1'b0;
      memread_reg  <= 1'b0;
      memwrite_reg <= 1'b0;
    end else begin
      valid_reg    <= valid_next;
      pc_reg       <= pc_next;
      rs1_data_reg <= rs1_data_next;
      rs2_data_reg <= rs2_data_next;
      imm_reg      <= imm_next;
      rs1_reg      <= rs1_next;
      rs2_reg      <= rs2_next;
      rd_reg       <= rd_next;
      asel_reg     <= asel_next;
      bsel_reg     <= bsel_next;
      aluctr_reg   <= aluctr_next;
      regwrite_reg <= regwrite_next;
      memread_reg  <= memread_next;
      memwrite_reg <= memwrite_next;
    end
  end

  assign alu_da = asel_reg ? pc_reg : fwd_rs1;

  always_comb begin
    alu_db = fwd_rs2;
    case (bsel_reg)
      2'd0: alu_db = fwd_rs2;
      2'd1: alu_db = imm_reg;
      2'd2: alu_db = CONST_FOUR;
      2'd3: alu_db = '0;
      default: alu_db = fwd_rs2;
    endcase
  end

  assign alu_aluctr    = valid_reg ? aluctr_reg : 4'd0;
  assign ex_valid      = valid_reg;
  assign ex_rd         = rd_reg;
  assign ex_regwrite   = regwrite_reg;
  assign ex_memread    = memread_reg;
  assign ex_memwrite   = memwrite_reg;
  assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: a forwarding vector table plus hand-written
// sequences for reset, load-use, hold refresh and flush.
module tb_ex_operand_stage;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_asel;
  logic [1:0]  id_bsel;
  logic [3:0]  id_aluctr;
  logic        id_regwrite, id_memread, id_memwrite;
  logic        ex_ready, ex_flush;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_regwrite, wb_regwrite;
  logic [31:0] mem_result, wb_data;
  logic [31:0] alu_da, alu_db, ex_store_data;
  logic [3:0]  alu_aluctr;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_memread, ex_memwrite;

  int checks = 0;
  int errors = 0;

  ex_operand_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_asel(id_asel), .id_bsel(id_bsel), .id_aluctr(id_aluctr),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .ex_ready(ex_ready), .ex_flush(ex_flush),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_data(wb_data),
    .alu_da(alu_da), .alu_db(alu_db), .alu_aluctr(alu_aluctr),
    .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_store_data(ex_store_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        asel;
    logic [1:0]  bsel;
    logic [3:0]  aluctr;
    logic        rw, mr, mw;
    logic [4:0]  mrd;
    logic        mrw;
    logic [31:0] mres;
    logic [4:0]  wrd;
    logic        wrw;
    logic [31:0] wdat;
    logic [31:0] exp_da, exp_db, exp_sd;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs[NVEC];

  function automatic vec_t mk(
    input logic [31:0] pc, rs1d, rs2d, imm,
    input logic [4:0] rs1, rs2, rd,
    input logic asel, input logic [1:0] bsel, input logic [3:0] aluctr,
    input logic rw, mr, mw,
    input logic [4:0] mrd, input logic mrw, input logic [31:0] mres,
    input logic [4:0] wrd, input logic wrw, input logic [31:0] wdat,
    input logic [31:0] exp_da, exp_db, exp_sd);
    vec_t v;
    v.pc = pc; v.rs1d = rs1d; v.rs2d = rs2d; v.imm = imm;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.asel = asel; v.bsel = bsel; v.aluctr = aluctr;
    v.rw = rw; v.mr = mr; v.mw = mw;
    v.mrd = mrd; v.mrw = mrw; v.mres = mres;
    v.wrd = wrd; v.wrw = wrw; v.wdat = wdat;
    v.exp_da = exp_da; v.exp_db = exp_db; v.exp_sd = exp_sd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic set_id(input vec_t v);
    id_valid    = 1'b1;
    id_pc       = v.pc;
    id_rs1_data = v.rs1d;
    id_rs2_data = v.rs2d;
    id_imm      = v.imm;
    id_rs1      = v.rs1;
    id_rs2      = v.rs2;
    id_rd       = v.rd;
    id_asel     = v.asel;
    id_bsel     = v.bsel;
    id_aluctr   = v.aluctr;
    id_regwrite = v.rw;
    id_memread  = v.mr;
    id_memwrite = v.mw;
  endtask

  task automatic set_fwd(input vec_t v);
    mem_rd = v.mrd; mem_regwrite = v.mrw; mem_result = v.mres;
    wb_rd  = v.wrd; wb_regwrite  = v.wrw; wb_data    = v.wdat;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    // pc, rs1d, rs2d, imm, rs1, rs2, rd, asel, bsel, alu, rw, mr, mw, mrd, mrw, mres, wrd, wrw, wdat, da, db, sd
    vecs[0] = mk(32'h100, 32'h3, 32'h10, 32'h0, 5, 7, 6, 0, 0, 4'h8, 1, 0, 0,
                 5, 1, 32'h11, 0, 0, 32'h0, 32'h11, 32'h10, 32'h10);
    vecs[1] = mk(32'h104, 32'h3, 32'h22, 32'h0, 5, 2, 9, 0, 0, 4'h0, 1, 0, 0,
                 5, 1, 32'hA, 5, 1, 32'hB, 32'hA, 32'h22, 32'h22);
    vecs[2] = mk(32'h108, 32'h100, 32'h200, 32'h0, 1, 9, 10, 0, 0, 4'h2, 0, 0, 1,
                 4, 1, 32'hDEAD, 9, 1, 32'h99, 32'h100, 32'h99, 32'h99);
    vecs[3] = mk(32'h10C, 32'h0, 32'h0, 32'h0, 0, 0, 11, 0, 0, 4'h6, 1, 0, 0,
                 0, 1, 32'h55, 0, 1, 32'h66, 32'h0, 32'h0, 32'h0);
    vecs[4] = mk(32'h1000, 32'h9, 32'h6, 32'hFFFFFFF0, 5, 6, 12, 1, 1, 4'h0, 1, 0, 0,
                 5, 1, 32'h77, 7, 1, 32'h1, 32'h1000, 32'hFFFFFFF0, 32'h6);
    vecs[5] = mk(32'h2004, 32'h1, 32'h33, 32'h40, 4, 3, 1, 1, 2, 4'h0, 1, 0, 0,
                 2, 1, 32'h5, 3, 1, 32'h44, 32'h2004, 32'h4, 32'h44);
    vecs[6] = mk(32'h300, 32'h88, 32'h88, 32'h7, 8, 8, 13, 0, 3, 4'hF, 0, 0, 1,
                 8, 0, 32'h123, 8, 1, 32'h321, 32'h321, 32'h0, 32'h321);
    vecs[7] = mk(32'h304, 32'hAAAA5555, 32'h5555AAAA, 32'h0, 31, 30, 31, 0, 0, 4'hC, 1, 0, 0,
                 30, 1, 32'h1, 31, 1, 32'h2, 32'h2, 32'h1, 32'h1);
    vecs[8] = mk(32'h308, 32'h12345678, 32'h0F0F0F0F, 32'h0, 14, 15, 16, 0, 0, 4'h7, 1, 0, 0,
                 15, 0, 32'h999, 14, 0, 32'h888, 32'h12345678, 32'h0F0F0F0F, 32'h0F0F0F0F);

    // Reset state
    rst = 1'b1; ex_ready = 1'b1; ex_flush = 1'b0;
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_id(v); set_fwd(v); id_valid = 1'b0;
    #1;
    chk("reset_valid", 32'(ex_valid), 0);
    chk("reset_aluctr", 32'(alu_aluctr), 0);
    chk("reset_ctrl", {29'd0, ex_regwrite, ex_memread, ex_memwrite}, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("reset_id_ready", 32'(id_ready), 1);
    $display("reset: ex_valid=%0d id_ready=%0d", ex_valid, id_ready);

    // Forwarding table
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      set_id(vecs[i]);
      #1;
      chk($sformatf("v%0d_id_ready", i), 32'(id_ready), 1);
      @(posedge clk); #1;
      id_valid = 1'b0;
      set_fwd(vecs[i]);
      #1;
      chk($sformatf("v%0d_valid", i), 32'(ex_valid), 1);
      chk($sformatf("v%0d_aluctr", i), 32'(alu_aluctr), 32'(vecs[i].aluctr));
      chk($sformatf("v%0d_da", i), alu_da, vecs[i].exp_da);
      chk($sformatf("v%0d_db", i), alu_db, vecs[i].exp_db);
      chk($sformatf("v%0d_sd", i), ex_store_data, vecs[i].exp_sd);
      chk($sformatf("v%0d_rd", i), 32'(ex_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_ctrl", i), {29'd0, ex_regwrite, ex_memread, ex_memwrite},
          {29'd0, vecs[i].rw, vecs[i].mr, vecs[i].mw});
      $display("vec %0d: da=0x%08h db=0x%08h sd=0x%08h aluctr=%0h", i, alu_da, alu_db,
               ex_store_data, alu_aluctr);
    end

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID
    @(negedge clk);
    v = mk(32'h400, 32'h100, 32'h0, 32'h8, 1, 0, 5, 0, 1, 4'h0, 1, 1, 0,
           0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_id(v); set_fwd(v);
    @(posedge clk); #1;
    chk("lu_lw_memread", 32'(ex_memread), 1);
    chk("lu_lw_db", alu_db, 32'h8);
    @(negedge clk);
    v = mk(32'h404, 32'h3, 32'h20, 32'h0, 5, 1, 6, 0, 0, 4'h3, 1, 0, 0,
           0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_id(v);
    #1;
    chk("lu_stall_id_ready", 32'(id_ready), 0);
    @(posedge clk); #1;
    chk("lu_bubble_valid", 32'(ex_valid), 0);
    chk("lu_bubble_aluctr", 32'(alu_aluctr), 0);
    chk("lu_bubble_ctrl", {29'd0, ex_regwrite, ex_memread, ex_memwrite}, 0);
    @(negedge clk); #1;
    chk("lu_release_id_ready", 32'(id_ready), 1);
    @(posedge clk); #1;
    id_valid = 1'b0;
    wb_rd = 5; wb_regwrite = 1'b1; wb_data = 32'hCAFE;
    #1;
    chk("lu_add_valid", 32'(ex_valid), 1);
    chk("lu_add_aluctr", 32'(alu_aluctr), 3);
    chk("lu_add_da", alu_da, 32'hCAFE);
    chk("lu_add_db", alu_db, 32'h20);
    $display("load-use: add entered da=0x%08h db=0x%08h", alu_da, alu_db);

    // Hold refresh: WB source for rs2 visible only on the first stall cycle
    @(negedge clk);
    v = mk(32'h500, 32'h10, 32'h5, 32'h0, 1, 3, 7, 0, 0, 4'h1, 1, 0, 0,
           0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_id(v); set_fwd(v);
    @(posedge clk); #1;
    chk("hold_captured", 32'(ex_valid), 1);
    @(negedge clk);
    ex_ready = 1'b0;
    v = mk(32'h504, 32'h0, 32'h0, 32'h0, 0, 0, 8, 0, 0, 4'h5, 1, 0, 0,
           0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_id(v);
    wb_rd = 3; wb_regwrite = 1'b1; wb_data = 32'h77;
    #1;
    chk("hold_c1_db", alu_db, 32'h77);
    chk("hold_c1_id_ready", 32'(id_ready), 0);
    @(posedge clk); #1;
    wb_regwrite = 1'b0; wb_data = 32'h0;
    #1;
    chk("hold_c2_db", alu_db, 32'h77);
    chk("hold_c2_aluctr", 32'(alu_aluctr), 1);
    @(posedge clk); #1;
    chk("hold_c3_db", alu_db, 32'h77);
    chk("hold_c3_valid", 32'(ex_valid), 1);
    @(negedge clk);
    ex_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold_next_aluctr", 32'(alu_aluctr), 5);
    chk("hold_next_rd", 32'(ex_rd), 8);
    $display("hold: db held at 0x77, next aluctr=%0h", alu_aluctr);

    // Flush beats an ID capture
    @(negedge clk);
    v = mk(32'h600, 32'h1, 32'h2, 32'h0, 1, 2, 9, 0, 0, 4'h9, 1, 0, 0,
           0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_id(v);
    ex_flush = 1'b1;
    #1;
    chk("flush_id_ready", 32'(id_ready), 1);
    @(posedge clk); #1;
    chk("flush_valid", 32'(ex_valid), 0);
    chk("flush_regwrite", 32'(ex_regwrite), 0);
    chk("flush_aluctr", 32'(alu_aluctr), 0);
    // Flush also kills an instruction held by downstream stall
    @(negedge clk);
    ex_flush = 1'b0;
    @(posedge clk); #1;
    chk("flush2_captured", 32'(alu_aluctr), 9);
    @(negedge clk);
    id_valid = 1'b0; ex_ready = 1'b0; ex_flush = 1'b1;
    @(posedge clk); #1;
    chk("flush2_valid", 32'(ex_valid), 0);
    @(negedge clk);
    ex_flush = 1'b0; ex_ready = 1'b1;
    $display("flush: ex_valid=%0d ex_regwrite=%0d", ex_valid, ex_regwrite);

    // Asynchronous reset mid-stream
    @(negedge clk);
    v = mk(32'h700, 32'h1, 32'h2, 32'h0, 1, 2, 4, 0, 0, 4'h7, 1, 0, 0,
           0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_id(v);
    @(posedge clk); #1;
    chk("mrst_before_valid", 32'(ex_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_valid", 32'(ex_valid), 0);
    chk("mrst_aluctr", 32'(alu_aluctr), 0);
    chk("mrst_regwrite", 32'(ex_regwrite), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_id_ready", 32'(id_ready), 1);
    @(posedge clk); #1;
    chk("mrst_after_valid", 32'(ex_valid), 1);
    chk("mrst_after_aluctr", 32'(alu_aluctr), 7);
    $display("mid reset: recovered ex_valid=%0d aluctr=%0h", ex_valid, alu_aluctr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
